// File: rtl/writeback.sv
// uRISC WB stage: architectural register file with write-through bypass reads,
// saturating retired-instruction counter and the halt-drain FSM.
module writeback #(
  parameter  int NUM_REGS     = 8,
  parameter  int DATA_W       = 16,
  parameter  int PC_W         = 16,
  parameter  int DRAIN_CYCLES = 2,
  parameter  int RETIRE_CNT_W = 32,
  localparam int IDX_W        = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       dest_reg_value_memwb_p5,
  input  logic [IDX_W-1:0]        dest_reg_index_memwb_p5,
  input  logic                    dest_reg_write_valid_memwb_p5,
  input  logic                    retire_valid_memwb_p5,
  input  logic [PC_W-1:0]         pc_p5,
  input  logic                    halt_idif_p3,
  input  logic [IDX_W-1:0]        rs_index_idwb_p2,
  input  logic [IDX_W-1:0]        rt_index_idwb_p2,
  output logic [DATA_W-1:0]       rs_value_wbid_p2,
  output logic [DATA_W-1:0]       rt_value_wbid_p2,
  output logic [RETIRE_CNT_W-1:0] retire_cnt_wb,
  output logic [PC_W-1:0]         last_pc_wb,
  output logic                    halted_wb
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t             state, state_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_next;
  logic [DATA_W-1:0]  rf [NUM_REGS];
  logic               wr_en, ret_en;

  assign wr_en  = dest_reg_write_valid_memwb_p5 && (state != HALTED);
  assign ret_en = retire_valid_memwb_p5 && (state != HALTED);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      RUN: begin
        if (halt_idif_p3) begin
          state_next     = DRAIN;
          drain_cnt_next = DRAIN_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        drain_cnt_next = drain_cnt - 1'b1;
        if (drain_cnt == DRAIN_W'(1)) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // NOTE: the register file is cleared on reset because software relies on all-zero registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[dest_reg_index_memwb_p5] <= dest_reg_value_memwb_p5;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_wb <= '0;
      last_pc_wb    <= '0;
    end else if (ret_en) begin
      if (retire_cnt_wb != '1) retire_cnt_wb <= retire_cnt_wb + 1'b1;
      last_pc_wb <= pc_p5;
    end
  end

  // A write landing this cycle is forwarded so decode never sees a stale value.
  assign rs_value_wbid_p2 = (wr_en && dest_reg_index_memwb_p5 == rs_index_idwb_p2)
                            ? dest_reg_value_memwb_p5 : rf[rs_index_idwb_p2];
  assign rt_value_wbid_p2 = (wr_en && dest_reg_index_memwb_p5 == rt_index_idwb_p2)
                            ? dest_reg_value_memwb_p5 : rf[rt_index_idwb_p2];

  assign halted_wb = (state == HALTED);

endmodule

// File: tb/tb_writeback.sv
// Directed testbench for writeback: reset, bypass, retire, halt drain, saturation, reset-in-drain.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wval;
  logic [2:0]  widx;
  logic        wvalid;
  logic        retire;
  logic [15:0] pc;
  logic        halt;
  logic [2:0]  rs_idx, rt_idx;
  logic [15:0] rs_val, rt_val;
  logic [31:0] cnt;
  logic [15:0] last_pc;
  logic        halted;

  logic [15:0] s_rs_val, s_rt_val, s_last_pc;
  logic [1:0]  s_cnt;
  logic        s_halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst(rst),
    .dest_reg_value_memwb_p5(wval), .dest_reg_index_memwb_p5(widx),
    .dest_reg_write_valid_memwb_p5(wvalid), .retire_valid_memwb_p5(retire),
    .pc_p5(pc), .halt_idif_p3(halt),
    .rs_index_idwb_p2(rs_idx), .rt_index_idwb_p2(rt_idx),
    .rs_value_wbid_p2(rs_val), .rt_value_wbid_p2(rt_val),
    .retire_cnt_wb(cnt), .last_pc_wb(last_pc), .halted_wb(halted)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  writeback #(.RETIRE_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .dest_reg_value_memwb_p5(wval), .dest_reg_index_memwb_p5(widx),
    .dest_reg_write_valid_memwb_p5(wvalid), .retire_valid_memwb_p5(retire),
    .pc_p5(pc), .halt_idif_p3(halt),
    .rs_index_idwb_p2(rs_idx), .rt_index_idwb_p2(rt_idx),
    .rs_value_wbid_p2(s_rs_val), .rt_value_wbid_p2(s_rt_val),
    .retire_cnt_wb(s_cnt), .last_pc_wb(s_last_pc), .halted_wb(s_halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wvalid = 0; retire = 0; halt = 0;
    wval = 16'h0; widx = 3'd0; pc = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rs_idx = 3'(i); rt_idx = 3'(7 - i);
      #1;
      checks++;
      if (rs_val !== 16'h0 || rt_val !== 16'h0) begin
        errors++;
        $display("FAIL reset_rf[%0d] rs=%h rt=%h expected 0000", i, rs_val, rt_val);
      end
    end
    checks++;
    if (cnt !== 32'h0 || halted !== 1'b0 || last_pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_state cnt=%h halted=%b last_pc=%h expected 0/0/0", cnt, halted, last_pc);
    end
  endtask

  task automatic test_bypass();
    wvalid = 1; widx = 3'd3; wval = 16'hBEEF; rs_idx = 3'd3; rt_idx = 3'd4;
    #1;
    checks++;
    if (rs_val !== 16'hBEEF) begin
      errors++; $display("FAIL bypass_rs got %h expected beef", rs_val);
    end
    checks++;
    if (rt_val !== 16'h0) begin
      errors++; $display("FAIL bypass_rt_other got %h expected 0000", rt_val);
    end
    tick();
    wvalid = 0; wval = 16'h0;
    #1;
    checks++;
    if (rs_val !== 16'hBEEF) begin
      errors++; $display("FAIL rf_after_write got %h expected beef", rs_val);
    end
  endtask

  task automatic test_no_write_retire();
    wvalid = 0; widx = 3'd5; wval = 16'h1234; rs_idx = 3'd5;
    #1;
    checks++;
    if (rs_val !== 16'h0) begin
      errors++; $display("FAIL no_write_bypass got %h expected 0000", rs_val);
    end
    tick();
    checks++;
    if (rs_val !== 16'h0) begin
      errors++; $display("FAIL no_write_rf got %h expected 0000", rs_val);
    end
    retire = 1; pc = 16'h0040;
    tick();
    retire = 0;
    checks++;
    if (cnt !== 32'd1 || last_pc !== 16'h0040) begin
      errors++; $display("FAIL retire cnt=%h last_pc=%h expected 1/0040", cnt, last_pc);
    end
  endtask

  task automatic test_back_to_back();
    // Each cycle writes Ri and reads R(i-1) (architectural) and Ri (bypass).
    for (int i = 0; i < 8; i++) begin
      wvalid = 1; widx = 3'(i); wval = 16'hA000 + 16'(i);
      rs_idx = 3'(i); rt_idx = 3'(i - 1);
      #1;
      checks++;
      if (rs_val !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL b2b_bypass[%0d] got %h expected %h", i, rs_val, 16'hA000 + 16'(i));
      end
      if (i > 0) begin
        checks++;
        if (rt_val !== 16'hA000 + 16'(i - 1)) begin
          errors++; $display("FAIL b2b_prev[%0d] got %h expected %h", i, rt_val, 16'hA000 + 16'(i - 1));
        end
      end
      tick();
    end
    wvalid = 0;
    rs_idx = 3'd6; rt_idx = 3'd6;
    #1;
    checks++;
    if (rs_val !== 16'hA006 || rt_val !== 16'hA006) begin
      errors++; $display("FAIL same_index rs=%h rt=%h expected a006", rs_val, rt_val);
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt = 1;                                     // cycle T
    tick();
    halt = 0; wvalid = 1; widx = 3'd1; wval = 16'h0011; retire = 1; pc = 16'h0100;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_t1 halted=%b expected 0", halted);
    end
    tick();                                       // T+2
    widx = 3'd2; wval = 16'h0022; pc = 16'h0102;
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_t2 halted=%b expected 0", halted);
    end
    tick();                                       // T+3
    idle_inputs();
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL halt_t3 halted=%b expected 1", halted);
    end
    checks++;
    if (cnt !== 32'd2 || last_pc !== 16'h0102) begin
      errors++; $display("FAIL drain_retire cnt=%h last_pc=%h expected 2/0102", cnt, last_pc);
    end
    tick();                                       // T+4
    wvalid = 1; widx = 3'd1; wval = 16'hFFFF; retire = 1; pc = 16'h0200; rt_idx = 3'd1;
    #1;
    checks++;
    if (rt_val !== 16'h0011) begin
      errors++; $display("FAIL halted_no_bypass got %h expected 0011", rt_val);
    end
    tick();
    idle_inputs();
    rs_idx = 3'd1; rt_idx = 3'd2;
    #1;
    checks++;
    if (rs_val !== 16'h0011 || rt_val !== 16'h0022) begin
      errors++; $display("FAIL halted_rf r1=%h r2=%h expected 0011/0022", rs_val, rt_val);
    end
    checks++;
    if (cnt !== 32'd2 || last_pc !== 16'h0102 || halted !== 1'b1) begin
      errors++; $display("FAIL halted_frozen cnt=%h last_pc=%h halted=%b expected 2/0102/1", cnt, last_pc, halted);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    retire = 1;
    for (int i = 1; i <= 5; i++) begin
      pc = 16'(i);
      tick();
      checks++;
      if (s_cnt !== ((i > 3) ? 2'd3 : 2'(i)) || cnt !== 32'(i)) begin
        errors++;
        $display("FAIL saturate[%0d] narrow=%0d wide=%0d expected %0d/%0d", i, s_cnt, cnt, (i > 3) ? 3 : i, i);
      end
    end
    retire = 0;
  endtask

  task automatic test_drain_reset();
    do_reset();
    wvalid = 1; widx = 3'd4; wval = 16'h5555;
    tick();
    idle_inputs();
    halt = 1;
    tick();
    halt = 0;
    rst = 1;                                      // reset while in DRAIN
    tick();
    rst = 0;
    rs_idx = 3'd4;
    #1;
    checks++;
    if (halted !== 1'b0 || rs_val !== 16'h0) begin
      errors++; $display("FAIL drain_reset halted=%b r4=%h expected 0/0000", halted, rs_val);
    end
    halt = 1;                                     // fresh halt at T
    tick();
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL redrain_t1 halted=%b expected 0", halted);
    end
    tick();                                       // halt re-asserted in DRAIN, ignored
    halt = 0;
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL redrain_t2 halted=%b expected 0", halted);
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL redrain_t3 halted=%b expected 1", halted);
    end
  endtask

  initial begin
    rst = 1; rs_idx = 0; rt_idx = 0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_no_write_retire();
    test_back_to_back();
    test_halt();
    test_saturate();
    test_drain_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
